// File: rtl/video_fill_blitter.sv
// Rectangle fill engine for a 320x200 4bpp frame buffer (160 bytes/row).
// Full bytes are written in one cycle; edge nibbles use a read-merge-write.
module video_fill_blitter (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [8:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [3:0]  cmd_color,
  output logic [14:0] vram_add,
  output logic [7:0]  vram_data,
  output logic        vram_we,
  input  logic [7:0]  vram_rd_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, SETUP, FULL_WR, RD, MRG, PART_WR} state_t;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] w;
    logic [7:0] h;
    logic [3:0] color;
  } cmd_t;

  state_t      state, state_nxt;
  cmd_t        cmd_q;
  logic        rdy_en;
  logic [14:0] row_addr, cur_addr;
  logic [7:0]  col, rows_left, rd_q;
  logic        done_q, err_q;

  logic [9:0]  x_end;
  logic [8:0]  y_end, last_px;
  logic [7:0]  first_b, last_b, nxt_col;
  logic [14:0] s_row;
  logic        cmd_ok, at_last, last_row, wr_state, first_part, nxt_part, keep_hi;

  assign x_end    = 10'(cmd_q.x) + 10'(cmd_q.w);
  assign y_end    = 9'(cmd_q.y) + 9'(cmd_q.h);
  assign last_px  = cmd_q.x + cmd_q.w - 9'd1;
  assign first_b  = cmd_q.x[8:1];
  assign last_b   = last_px[8:1];
  assign s_row    = {cmd_q.y, 7'b0} + 15'({cmd_q.y, 5'b0});
  assign cmd_ok   = (cmd_q.w != 9'd0) && (cmd_q.h != 8'd0) &&
                    (x_end <= 10'd320) && (y_end <= 9'd200);

  assign at_last  = (col == last_b);
  assign last_row = (rows_left == 8'd1);
  assign wr_state = (state == FULL_WR) || (state == PART_WR);
  assign nxt_col  = at_last ? first_b : col + 8'd1;

  // Odd start keeps the high nibble; even end keeps the low nibble.
  assign first_part = cmd_q.x[0] || ((first_b == last_b) && !last_px[0]);
  assign nxt_part   = ((nxt_col == first_b) && cmd_q.x[0]) ||
                      ((nxt_col == last_b) && !last_px[0]);
  assign keep_hi    = (col == first_b) && cmd_q.x[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid && cmd_ready) state_nxt = SETUP;
      SETUP:   if (!cmd_ok)        state_nxt = IDLE;
               else if (first_part) state_nxt = RD;
               else                 state_nxt = FULL_WR;
      RD:      state_nxt = MRG;
      MRG:     state_nxt = PART_WR;
      FULL_WR,
      PART_WR: if (at_last && last_row) state_nxt = IDLE;
               else if (nxt_part)       state_nxt = RD;
               else                     state_nxt = FULL_WR;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    vram_we   = 1'b0;
    vram_data = 8'h00;
    case (state)
      FULL_WR: begin
        vram_we   = 1'b1;
        vram_data = {cmd_q.color, cmd_q.color};
      end
      PART_WR: begin
        vram_we   = 1'b1;
        vram_data = keep_hi ? {rd_q[7:4], cmd_q.color} : {cmd_q.color, rd_q[3:0]};
      end
      default: ;
    endcase
  end

  assign vram_add  = cur_addr;
  assign busy      = (state != IDLE);
  assign cmd_ready = rdy_en && (state == IDLE);
  assign done      = done_q;
  assign err       = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q     <= '0;
      rdy_en    <= 1'b0;
      row_addr  <= '0;
      cur_addr  <= '0;
      col       <= '0;
      rows_left <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      done_q <= wr_state && at_last && last_row;
      err_q  <= (state == SETUP) && !cmd_ok;
      if (cmd_valid && cmd_ready)
        cmd_q <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
      if (state == SETUP) begin
        row_addr  <= s_row;
        cur_addr  <= s_row + 15'(first_b);
        col       <= first_b;
        rows_left <= cmd_q.h;
      end
      if (state == MRG) rd_q <= vram_rd_data;
      if (wr_state) begin
        if (at_last) begin
          rows_left <= rows_left - 8'd1;
          col       <= first_b;
          // Hold the address on the final row so it never points past the frame.
          if (!last_row) begin
            row_addr <= row_addr + 15'd160;
            cur_addr <= row_addr + 15'd160 + 15'(first_b);
          end
        end else begin
          col      <= col + 8'd1;
          cur_addr <= cur_addr + 15'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_fill_blitter.sv
// Bench for video_fill_blitter: pixel-level frame-buffer model plus cycle
// counts derived from bytes touched, with directed and random commands.
module tb_video_fill_blitter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_x = '0;
  logic [7:0]  cmd_y = '0;
  logic [8:0]  cmd_w = '0;
  logic [7:0]  cmd_h = '0;
  logic [3:0]  cmd_color = '0;
  logic [14:0] vram_add;
  logic [7:0]  vram_data;
  logic        vram_we;
  logic [7:0]  vram_rd_data = '0;
  logic        busy, done, err;

  video_fill_blitter dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .vram_add(vram_add), .vram_data(vram_data), .vram_we(vram_we),
    .vram_rd_data(vram_rd_data), .busy(busy), .done(done), .err(err)
  );

  always #10 clk = ~clk;

  logic [7:0] mem     [32000];
  logic [7:0] exp_mem [32000];
  bit         wflag   [32000];
  logic [7:0] rd_lat = '0;
  int n_chk = 0, n_fail = 0;
  int wr_cnt, dup_cnt, oob_cnt;

  always @(posedge clk) vram_rd_data <= rd_lat;

  task automatic chk(input string tag, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp_v, exp_v);
    end
  endtask

  // One cycle: the RAM model commits writes and latches reads mid-cycle.
  task automatic step();
    @(negedge clk);
    if (vram_we) begin
      wr_cnt++;
      if (vram_add >= 15'd32000) oob_cnt++;
      else begin
        if (wflag[vram_add]) dup_cnt++;
        wflag[vram_add] = 1'b1;
        mem[vram_add]   = vram_data;
      end
    end
    rd_lat = (vram_add < 15'd32000) ? mem[vram_add] : 8'h00;
    #1;
  endtask

  task automatic snapshot();
    for (int a = 0; a < 32000; a++) begin
      exp_mem[a] = mem[a];
      wflag[a]   = 1'b0;
    end
    wr_cnt = 0; dup_cnt = 0; oob_cnt = 0;
  endtask

  task automatic mem_cmp(input string tag);
    int mism = 0;
    for (int a = 0; a < 32000; a++) if (mem[a] !== exp_mem[a]) mism++;
    chk(tag, mism, 0);
  endtask

  // Paint pixels into exp_mem and derive cycle count from bytes touched per row.
  task automatic model(input int x, input int y, input int w, input int h, input int c,
                       output bit ok, output int lat, output int nwr);
    int nfull = 0, npart = 0;
    ok  = (w > 0) && (h > 0) && (x + w <= 320) && (y + h <= 200);
    lat = 1; nwr = 0;
    if (!ok) return;
    for (int yy = y; yy < y + h; yy++)
      for (int xx = x; xx < x + w; xx++) begin
        int a = yy * 160 + xx / 2;
        if (xx % 2 == 0) exp_mem[a][7:4] = 4'(c);
        else             exp_mem[a][3:0] = 4'(c);
      end
    for (int b = x / 2; b <= (x + w - 1) / 2; b++) begin
      int pix = 0;
      for (int xx = x; xx < x + w; xx++) if (xx / 2 == b) pix++;
      if (pix == 2) nfull++; else npart++;
    end
    lat = 1 + h * (nfull + 3 * npart);
    nwr = h * (nfull + npart);
  endtask

  // Present a command and return just after the accepting edge (valid left high).
  task automatic drive(input int x, input int y, input int w, input int h, input int c);
    int g = 0;
    cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = 4'(c);
    cmd_valid = 1'b1;
    while (!cmd_ready && g < 50) begin step(); g++; end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_end(input bit ok, input int lat, output int end_cyc, output int bad);
    int cyc = 0;
    end_cyc = -1; bad = 0;
    while (cyc < lat + 20) begin
      step(); cyc++;
      if (ok ? done : err) begin
        end_cyc = cyc;
        if (ok ? err : done) bad++;
        break;
      end
      if (!busy || done || err) bad++;
    end
  endtask

  task automatic run_cmd(input int x, input int y, input int w, input int h, input int c,
                         input string tag);
    bit ok; int lat, nwr, e, bad;
    snapshot();
    model(x, y, w, h, c, ok, lat, nwr);
    drive(x, y, w, h, c);
    cmd_valid = 1'b0;
    wait_end(ok, lat, e, bad);
    chk({tag, "_end_cycle"}, e, ok ? lat + 1 : 2);
    chk({tag, "_proto"}, bad, 0);
    if (ok) begin
      chk({tag, "_rdy_at_done"}, int'(cmd_ready), 1);
      chk({tag, "_busy_at_done"}, int'(busy), 0);
    end else begin
      step();
      chk({tag, "_rdy_after_err"}, int'(cmd_ready), 1);
    end
    chk({tag, "_writes"}, wr_cnt, nwr);
    chk({tag, "_dup_oob"}, dup_cnt + oob_cnt, 0);
    mem_cmp({tag, "_mem"});
  endtask

  initial begin
    bit ok1, ok2; int lat1, lat2, n1, n2, e, bad, cyc, acc, dn;
    for (int a = 0; a < 32000; a++) mem[a] = 8'($urandom);
    wr_cnt = 0; dup_cnt = 0; oob_cnt = 0;

    // Reset state
    #1 rst = 1'b1;
    step(); step();
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_we", int'(vram_we), 0);
    chk("rst_add", int'(vram_add), 0);
    chk("rst_data", int'(vram_data), 0);
    chk("rst_flags", int'({busy, done, err}), 0);
    rst = 1'b0; #1;
    chk("rls_ready_before_edge", int'(cmd_ready), 0);
    step();
    chk("rls_ready_after_edge", int'(cmd_ready), 1);

    // Directed cases
    run_cmd(0, 0, 320, 1, 5, "full_row");
    mem[0] = 8'h3C;
    run_cmd(1, 0, 1, 1, 10, "odd_pixel");
    chk("odd_pixel_byte0", int'(mem[0]), 8'h3A);
    mem[31842] = 8'h12;
    run_cmd(2, 199, 3, 1, 15, "right_edge");
    chk("right_edge_31841", int'(mem[31841]), 8'hFF);
    chk("right_edge_31842", int'(mem[31842]), 8'hF2);
    run_cmd(318, 0, 3, 1, 7, "reject_x");
    run_cmd(0, 199, 1, 2, 7, "reject_y");
    run_cmd(319, 5, 1, 2, 4, "last_col");

    // Randomized commands, some deliberately out of range
    for (int i = 0; i < 14; i++) begin
      int x, y, w, h, k;
      x = $urandom_range(0, 319);
      w = $urandom_range(1, (320 - x < 24) ? 320 - x : 24);
      y = $urandom_range(0, 199);
      h = $urandom_range(1, (200 - y < 5) ? 200 - y : 5);
      k = $urandom_range(0, 6);
      if (k == 0) w = 0;
      if (k == 1) w = 321 - x;
      if (k == 2) h = 201 - y;
      if (k == 3) h = 0;
      run_cmd(x, y, w, h, $urandom_range(0, 15), $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a fill
    snapshot();
    for (int a = 0; a < 50; a++) exp_mem[a] = 8'h11;
    drive(0, 0, 320, 10, 1);
    cmd_valid = 1'b0;
    cyc = 0;
    while (wr_cnt < 50 && cyc < 200) begin step(); cyc++; end
    rst = 1'b1; #1;
    chk("midrst_we", int'(vram_we), 0);
    chk("midrst_busy", int'(busy), 0);
    dn = 0;
    for (int i = 0; i < 4; i++) begin step(); if (done) dn++; end
    chk("midrst_no_done", dn, 0);
    chk("midrst_writes", wr_cnt, 50);
    mem_cmp("midrst_mem");
    rst = 1'b0; #1;
    chk("midrst_rdy_low", int'(cmd_ready), 0);
    step();
    chk("midrst_rdy_high", int'(cmd_ready), 1);
    run_cmd(10, 100, 9, 3, 6, "post_rst");

    // Second command held on cmd_valid during a fill
    snapshot();
    model(4, 10, 8, 2, 3, ok1, lat1, n1);
    model(7, 20, 5, 1, 9, ok2, lat2, n2);
    drive(4, 10, 8, 2, 3);
    cmd_x = 9'd7; cmd_y = 8'd20; cmd_w = 9'd5; cmd_h = 8'd1; cmd_color = 4'd9;
    cyc = 0; acc = -1; dn = 0;
    while (cyc < lat1 + 20) begin
      step(); cyc++;
      if (cmd_ready) begin acc = cyc; dn = int'(done); break; end
    end
    chk("hold_accept_cycle", acc, lat1 + 1);
    chk("hold_done_same_cycle", dn, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_end(ok2, lat2, e, bad);
    chk("hold_second_end", e, lat2 + 1);
    chk("hold_proto", bad, 0);
    chk("hold_writes", wr_cnt, n1 + n2);
    chk("hold_dup_oob", dup_cnt + oob_cnt, 0);
    mem_cmp("hold_mem");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
